// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller at the M stage: SR/Cause/EPC state, exception and
// interrupt take decision, eret retirement and mfc0/mtc0 access.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID         = 32'h0000_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exc_code_m,
    input  logic [5:0]  hw_int,
    input  logic        eret_m,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] epc_out,
    output logic        exc_req,
    output logic        eret_req
);

    typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_t;

    localparam logic [4:0] A_SR    = 5'd12;
    localparam logic [4:0] A_CAUSE = 5'd13;
    localparam logic [4:0] A_EPC   = 5'd14;
    localparam logic [4:0] A_PRID  = 5'd15;

    state_t      state;      // doubles as SR.EXL
    logic [5:0]  sr_im;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        exl;
    logic        int_pend;
    logic        mtc0_go;
    logic [31:0] pc_aligned;
    logic [31:0] epc_next;

    // The handler address is consumed by the PC mux outside this block.
    logic unused_bits;
    assign unused_bits = ^{HANDLER_ADDR, pc_m[1:0]};

    assign exl        = (state == HANDLER);
    assign int_pend   = sr_ie & ~exl & |(hw_int & sr_im);
    assign exc_req    = m_valid & ~exl & (int_pend | (exc_code_m != 5'd0));
    assign eret_req   = m_valid & eret_m & exl & ~exc_req;
    assign mtc0_go    = m_valid & mtc0_we & ~exc_req;
    assign pc_aligned = {pc_m[31:2], 2'b00};
    assign epc_next   = bd_m ? pc_aligned - 32'd4 : pc_aligned;
    assign epc_out    = epc;

    always_comb begin
        rdata = 32'd0;
        case (cp0_addr)
            A_SR:    rdata = {16'd0, sr_im, 8'd0, exl, sr_ie};
            A_CAUSE: rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
            A_EPC:   rdata = epc;
            A_PRID:  rdata = PRID;
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= NORMAL;
            sr_im     <= 6'd0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= hw_int;
            case (state)
                NORMAL: begin
                    if (exc_req) begin
                        state     <= HANDLER;
                        cause_bd  <= bd_m;
                        cause_exc <= int_pend ? 5'd0 : exc_code_m;
                        epc       <= epc_next;
                    end
                end
                HANDLER: begin
                    if (eret_req)
                        state <= NORMAL;
                end
                default: state <= NORMAL;
            endcase
            // exc_req already gates mtc0_go, so a flushed mtc0 never lands.
            if (mtc0_go) begin
                if (cp0_addr == A_SR) begin
                    sr_im <= wdata[15:10];
                    sr_ie <= wdata[0];
                end
                if (cp0_addr == A_EPC)
                    epc <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with hand-computed expected values.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic [5:0]  hw_int;
    logic        eret_m;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] epc_out;
    logic        exc_req;
    logic        eret_req;

    int n_cmp = 0;
    int n_bad = 0;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .pc_m(pc_m), .bd_m(bd_m),
        .exc_code_m(exc_code_m), .hw_int(hw_int), .eret_m(eret_m),
        .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .wdata(wdata),
        .rdata(rdata), .epc_out(epc_out), .exc_req(exc_req), .eret_req(eret_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_valid = 0; pc_m = 0; bd_m = 0; exc_code_m = 0;
        eret_m = 0; mtc0_we = 0; cp0_addr = 0; wdata = 0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic do_eret(input string tag, input logic [31:0] exp_epc);
        idle();
        m_valid = 1; eret_m = 1;
        #1;
        chk({tag, "_eret_req"}, {31'd0, eret_req}, 32'd1);
        chk({tag, "_eret_epc"}, epc_out, exp_epc);
        tick();
        idle();
    endtask

    initial begin
        idle();
        hw_int = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        // reset state
        chk("rst_exc", {31'd0, exc_req}, 32'd0);
        chk("rst_eret", {31'd0, eret_req}, 32'd0);
        chk("rst_epc_out", epc_out, 32'd0);
        rd("rst_sr", 5'd12, 32'd0);
        rd("rst_cause", 5'd13, 32'd0);
        rd("rst_epc", 5'd14, 32'd0);
        rd("rst_prid", 5'd15, 32'h0000_0007);

        // overflow exception
        m_valid = 1; pc_m = 32'h3010; exc_code_m = 5'd12;
        #1;
        chk("ov_exc", {31'd0, exc_req}, 32'd1);
        chk("ov_eret", {31'd0, eret_req}, 32'd0);
        tick();
        idle();
        chk("ov_epc", epc_out, 32'h3010);
        rd("ov_cause", 5'd13, 32'h0000_0030);
        rd("ov_sr", 5'd12, 32'h0000_0002);
        m_valid = 1; exc_code_m = 5'd10;
        #1;
        chk("nested_masked", {31'd0, exc_req}, 32'd0);
        tick();

        // eret from handler, then eret from NORMAL is a no-op
        do_eret("e1", 32'h3010);
        rd("e1_sr", 5'd12, 32'd0);
        m_valid = 1; eret_m = 1;
        #1;
        chk("eret_normal", {31'd0, eret_req}, 32'd0);
        tick();
        idle();
        rd("eret_normal_sr", 5'd12, 32'd0);

        // delay-slot exception
        m_valid = 1; pc_m = 32'h3024; bd_m = 1; exc_code_m = 5'd4;
        #1;
        chk("bd_exc", {31'd0, exc_req}, 32'd1);
        tick();
        idle();
        chk("bd_epc", epc_out, 32'h3020);
        rd("bd_cause", 5'd13, 32'h8000_0010);
        do_eret("e2", 32'h3020);

        // interrupt beats the internal exception
        m_valid = 1; mtc0_we = 1; cp0_addr = 5'd12; wdata = 32'h0000_0401;
        tick();
        idle();
        rd("mtc0_sr", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        m_valid = 1; pc_m = 32'h3040; exc_code_m = 5'd12;
        #1;
        chk("int_exc", {31'd0, exc_req}, 32'd1);
        tick();
        idle();
        chk("int_epc", epc_out, 32'h3040);
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_sr", 5'd12, 32'h0000_0403);
        do_eret("e3", 32'h3040);
        rd("e3_sr", 5'd12, 32'h0000_0401);

        // bubble with pending interrupt and exception code
        m_valid = 0; exc_code_m = 5'd12; pc_m = 32'h3040;
        #1;
        chk("bubble_exc", {31'd0, exc_req}, 32'd0);
        tick();
        idle();

        // IE clear: interrupt alone is masked, exception still taken
        hw_int = 0;
        m_valid = 1; mtc0_we = 1; cp0_addr = 5'd12; wdata = 32'h0000_0400;
        tick();
        idle();
        hw_int = 6'b000001;
        m_valid = 1; pc_m = 32'h3040;
        #1;
        chk("ie_clr_int_only", {31'd0, exc_req}, 32'd0);
        exc_code_m = 5'd12;
        #1;
        chk("ie_clr_exc", {31'd0, exc_req}, 32'd1);
        tick();
        idle();
        rd("ie_clr_cause", 5'd13, 32'h0000_0430);
        do_eret("e4", 32'h3040);

        // mtc0 EPC flushed by a same-cycle exception
        hw_int = 0;
        m_valid = 1; mtc0_we = 1; cp0_addr = 5'd14; wdata = 32'h5000;
        pc_m = 32'h3050; exc_code_m = 5'd10;
        #1;
        chk("sim_exc", {31'd0, exc_req}, 32'd1);
        tick();
        idle();
        chk("sim_epc", epc_out, 32'h3050);
        rd("sim_cause", 5'd13, 32'h0000_0028);
        rd("sim_sr", 5'd12, 32'h0000_0402);

        // mtc0 EPC inside handler is honoured
        m_valid = 1; mtc0_we = 1; cp0_addr = 5'd14; wdata = 32'h5000;
        tick();
        idle();
        chk("h_mtc0_epc", epc_out, 32'h5000);
        do_eret("e5", 32'h5000);

        // writes to Cause are ignored
        m_valid = 1; mtc0_we = 1; cp0_addr = 5'd13; wdata = 32'hffff_ffff;
        tick();
        idle();
        rd("cause_ro", 5'd13, 32'h0000_0028);

        // reset overrides a concurrent exception
        hw_int = 6'h3f;
        m_valid = 1; pc_m = 32'h3060; exc_code_m = 5'd12;
        reset = 1;
        tick();
        reset = 0;
        idle();
        hw_int = 0;
        #1;
        rd("rr_sr", 5'd12, 32'd0);
        rd("rr_cause", 5'd13, 32'd0);
        chk("rr_epc", epc_out, 32'd0);
        chk("rr_exc", {31'd0, exc_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
